tempo_sequencer_clk: RTL and testbench

//  Parametrised tempo selector and beat generator for the step sequencer.
//  - Holds a table of NUM_TEMPOS tempos. Each entry is BPM_BASE + i*BPM_STEP.
//  - Up/down buttons step through the table, with wrap-around at both ends.
//  - Outputs the active beat period and a one-cycle beat_pulse, which the measure counter consumes.

---
 rtl/tempo_sequencer_clk_if.sv | 26 ++
 rtl/tempo_sequencer_clk.sv | 135 +++++++++++++
 tb/tb_tempo_sequencer_clk.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tempo_sequencer_clk_if.sv
// Tempo sequencer bus: button/run controls toward the sequencer and the
// active tempo plus beat/tempo-change pulses back toward the consumer.
interface tempo_sequencer_clk_if #(
  parameter int IDX_W = 3,
  parameter int CNT_W = 23
);
  logic             tempo_up;
  logic             tempo_down;
  logic             run;
  logic [IDX_W-1:0] tempo_idx;
  logic [CNT_W-1:0] tempo;
  logic             beat_pulse;
  logic             tempo_changed;

  // Controller side: drives buttons and run, observes tempo and beats.
  modport master (
    output tempo_up, tempo_down, run,
    input  tempo_idx, tempo, beat_pulse, tempo_changed
  );

  // Sequencer side.
  modport slave (
    input  tempo_up, tempo_down, run,
    output tempo_idx, tempo, beat_pulse, tempo_changed
  );
endinterface

// File: rtl/tempo_sequencer_clk.sv
// Tempo selector and beat generator for the step sequencer.
// A constant table holds NUM_TEMPOS beat periods (BPM_BASE + i*BPM_STEP),
// up/down button presses step through it with wrap-around, and a beat
// counter emits a one-cycle beat_pulse every tempo+1 cycles while run=1.
// Optional feature: define AUTO_REPEAT_EN to step again every REPEAT_CYC
// cycles while exactly one button stays held.
module tempo_sequencer_clk #(
  parameter int CLK_HZ     = 10_000_000,
  parameter int NUM_TEMPOS = 8,
  parameter int BPM_BASE   = 120,
  parameter int BPM_STEP   = 40,
  parameter int RESET_IDX  = 3,
  parameter int CNT_W      = 23,
  parameter int IDX_W      = $clog2(NUM_TEMPOS)
`ifdef AUTO_REPEAT_EN
  , parameter int REPEAT_CYC = 2_500_000
`endif
) (
  input logic                  clk,
  input logic                  rst,
  tempo_sequencer_clk_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TEMPOS - 1);
  localparam logic [IDX_W-1:0] RST_IDX  = IDX_W'(RESET_IDX);

  // Beat period in cycles minus one; only ever called with constant arguments.
  function automatic longint period_of(input int idx);
    return (longint'(CLK_HZ) * 60) / longint'(BPM_BASE + idx * BPM_STEP) - 1;
  endfunction

  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(period_of(RESET_IDX));

  // NOTE: the period table is pure constants folded at elaboration, so it is
  // a ROM with nothing to reset; only the state registers below get reset.
  logic [CNT_W-1:0] period_tab [NUM_TEMPOS];
  for (genvar g = 0; g < NUM_TEMPOS; g++) begin : g_tab
    localparam logic [CNT_W-1:0] PERIOD = CNT_W'(period_of(g));
    assign period_tab[g] = PERIOD;
  end

  logic             up_q, down_q;
  logic             press_up, press_down;
  logic             step_up, step_down;
  logic [IDX_W-1:0] idx_q, next_idx;
  logic [CNT_W-1:0] tempo_q;
  logic             changed_q;
  logic [CNT_W-1:0] cnt_q;
  logic             beat_q;

  assign press_up   = bus.tempo_up   & ~up_q;
  assign press_down = bus.tempo_down & ~down_q;

`ifdef AUTO_REPEAT_EN
  localparam int REP_W = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;

  logic [REP_W-1:0] rep_cnt;
  logic             one_held;
  logic             rep_fire;

  assign one_held = bus.tempo_up ^ bus.tempo_down;
  assign rep_fire = one_held && !(press_up || press_down) &&
                    (rep_cnt == REP_W'(REPEAT_CYC - 1));

  // Repeat counter: restarts on any press, cleared when released or both held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt <= '0;
    end else if (press_up || press_down || !one_held || rep_fire) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end

  assign step_up   = (press_up   & ~press_down) | (rep_fire & bus.tempo_up);
  assign step_down = (press_down & ~press_up)   | (rep_fire & bus.tempo_down);
`else
  assign step_up   = press_up   & ~press_down;
  assign step_down = press_down & ~press_up;
`endif

  // Next table index with wrap-around at both ends.
  always_comb begin
    // NOTE: default assignment first, so every path drives next_idx and no latch is inferred.
    next_idx = idx_q;
    if (step_up) begin
      next_idx = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end else if (step_down) begin
      next_idx = (idx_q == '0) ? LAST_IDX : idx_q - 1'b1;
    end
  end

  // Button history, active index/period and the tempo_changed pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // History starts high so a button held through reset release is not a press.
      up_q      <= 1'b1;
      down_q    <= 1'b1;
      idx_q     <= RST_IDX;
      tempo_q   <= RST_PERIOD;
      changed_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      up_q      <= bus.tempo_up;
      down_q    <= bus.tempo_down;
      idx_q     <= next_idx;
      tempo_q   <= period_tab[next_idx];
      changed_q <= step_up | step_down;
    end
  end

  // Beat counter: >= compare makes a shrunken period fire on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      beat_q <= 1'b0;
    end else if (!bus.run) begin
      cnt_q  <= '0;
      beat_q <= 1'b0;
    end else if (cnt_q >= tempo_q) begin
      cnt_q  <= '0;
      beat_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      beat_q <= 1'b0;
    end
  end

  assign bus.tempo_idx     = idx_q;
  assign bus.tempo         = tempo_q;
  assign bus.beat_pulse    = beat_q;
  assign bus.tempo_changed = changed_q;

endmodule

// File: tb/tb_tempo_sequencer_clk.sv
// Self-checking bench for tempo_sequencer_clk (periods 599/299/199/149).
// Expected beat pulses and tempo changes are queued when stimulus is driven
// and matched by negedge monitors; tasks also check state inline.
module tb_tempo_sequencer_clk;
  localparam int CLK_HZ     = 600;
  localparam int NUM_TEMPOS = 4;
  localparam int BPM_BASE   = 60;
  localparam int BPM_STEP   = 60;
  localparam int RESET_IDX  = 1;
  localparam int CNT_W      = 10;
  localparam int IDX_W      = 2;

  typedef struct {
    int cyc;
    int idx;
    int period;
  } chg_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_idx;
  int   exp_tab [NUM_TEMPOS] = '{599, 299, 199, 149};
  int   beat_exp_q [$];
  chg_t chg_exp_q [$];
  int   mon_beat;
  chg_t mon_chg;

  tempo_sequencer_clk_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

  tempo_sequencer_clk #(
    .CLK_HZ    (CLK_HZ),
    .NUM_TEMPOS(NUM_TEMPOS),
    .BPM_BASE  (BPM_BASE),
    .BPM_STEP  (BPM_STEP),
    .RESET_IDX (RESET_IDX),
    .CNT_W     (CNT_W),
    .IDX_W     (IDX_W)
`ifdef AUTO_REPEAT_EN
    , .REPEAT_CYC(10)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Beat scoreboard: every pulse must match the oldest expected cycle.
  always @(negedge clk) begin
    if (!rst && bus.beat_pulse) begin
      vectors++;
      if (beat_exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL beat_unexpected: pulse at cycle %0d, none expected", cyc);
      end else begin
        mon_beat = beat_exp_q.pop_front();
        if (cyc !== mon_beat) begin
          miscompares++;
          $display("FAIL beat_cycle: got cycle %0d, expected %0d", cyc, mon_beat);
        end
      end
    end
  end

  // Tempo-change scoreboard: cycle, index and period of each change.
  always @(negedge clk) begin
    if (!rst && bus.tempo_changed) begin
      vectors++;
      if (chg_exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL chg_unexpected: tempo_changed at cycle %0d idx %0d", cyc, bus.tempo_idx);
      end else begin
        mon_chg = chg_exp_q.pop_front();
        if (cyc !== mon_chg.cyc || int'(bus.tempo_idx) !== mon_chg.idx ||
            int'(bus.tempo) !== mon_chg.period) begin
          miscompares++;
          $display("FAIL chg_value: got cyc %0d idx %0d tempo %0d, expected cyc %0d idx %0d tempo %0d",
                   cyc, bus.tempo_idx, bus.tempo, mon_chg.cyc, mon_chg.idx, mon_chg.period);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_state(input string name);
    vectors++;
    if (int'(bus.tempo_idx) !== exp_idx || int'(bus.tempo) !== exp_tab[exp_idx]) begin
      miscompares++;
      $display("FAIL %s: got idx %0d tempo %0d, expected idx %0d tempo %0d",
               name, bus.tempo_idx, bus.tempo, exp_idx, exp_tab[exp_idx]);
    end
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (beat_exp_q.size() != 0 || chg_exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d beats and %0d tempo changes never seen",
               name, beat_exp_q.size(), chg_exp_q.size());
      beat_exp_q.delete();
      chg_exp_q.delete();
    end
  endtask

  // One-cycle press of the given buttons; queues the expected change.
  task automatic press(input bit up, input bit dn);
    chg_t c;
    if (up != dn) begin
      exp_idx  = up ? (exp_idx + 1) % NUM_TEMPOS : (exp_idx + NUM_TEMPOS - 1) % NUM_TEMPOS;
      c.cyc    = cyc + 1;
      c.idx    = exp_idx;
      c.period = exp_tab[exp_idx];
      chg_exp_q.push_back(c);
    end
    bus.tempo_up   = up;
    bus.tempo_down = dn;
    tick(1);
    bus.tempo_up   = 1'b0;
    bus.tempo_down = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    bus.tempo_up   = 1'b0;
    bus.tempo_down = 1'b0;
    bus.run        = 1'b0;
    rst            = 1'b1;
    exp_idx        = RESET_IDX;
    tick(3);
    check_state("reset_state");
    vectors++;
    if (bus.beat_pulse !== 1'b0 || bus.tempo_changed !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_pulses: got beat %b changed %b, expected 0 0",
               bus.beat_pulse, bus.tempo_changed);
    end
    rst = 1'b0;
    tick(5);
    check_state("after_reset_release");
  endtask

  task automatic test_beat();
    int e;
    e = cyc;
    bus.run = 1'b1;
    beat_exp_q.push_back(e + 300);
    beat_exp_q.push_back(e + 600);
    beat_exp_q.push_back(e + 900);
    tick(950);
    bus.run = 1'b0;
    tick(700);
    check_drained("beat_period_299");
  endtask

  task automatic test_stepping();
    for (int i = 0; i < 4; i++) begin
      press(1'b1, 1'b0);
      check_state("step_up");
    end
    press(1'b0, 1'b1);
    check_state("step_down_to_0");
    press(1'b0, 1'b1);
    check_state("step_down_wrap");
    tick(3);
    check_drained("stepping");
  endtask

  task automatic test_both_buttons();
    bus.tempo_up   = 1'b1;
    bus.tempo_down = 1'b1;
    tick(1);
    vectors++;
    if (bus.tempo_changed !== 1'b0) begin
      miscompares++;
      $display("FAIL both_pressed_changed: got %b, expected 0", bus.tempo_changed);
    end
    bus.tempo_up   = 1'b0;
    bus.tempo_down = 1'b0;
    tick(3);
    check_state("both_pressed_idx");
  endtask

  task automatic test_mid_beat_change();
    int e;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check_state("back_to_idx1");
    e = cyc;
    bus.run = 1'b1;
    tick(250);
    exp_idx = 2;
    chg_exp_q.push_back('{cyc: e + 251, idx: 2, period: 199});
    beat_exp_q.push_back(e + 252);
    beat_exp_q.push_back(e + 452);
    beat_exp_q.push_back(e + 652);
    bus.tempo_up = 1'b1;
    tick(1);
    bus.tempo_up = 1'b0;
    tick(409);
    bus.run = 1'b0;
    tick(300);
    check_state("mid_beat_idx");
    check_drained("mid_beat_shrink");
  endtask

  task automatic test_reset_hold();
    bus.tempo_up = 1'b1;
    #2;
    rst     = 1'b1;
    exp_idx = RESET_IDX;
    #2;
    check_state("async_reset_mid_op");
    tick(2);
    rst = 1'b0;
    tick(50);
    check_state("held_through_reset");
    bus.tempo_up = 1'b0;
    tick(3);
    check_drained("reset_hold");
  endtask

  task automatic test_hold();
    int e;
    e = cyc;
    chg_exp_q.push_back('{cyc: e + 1, idx: 2, period: 199});
`ifdef AUTO_REPEAT_EN
    chg_exp_q.push_back('{cyc: e + 11, idx: 3, period: 149});
    chg_exp_q.push_back('{cyc: e + 21, idx: 0, period: 599});
    exp_idx = 0;
`else
    exp_idx = 2;
`endif
    bus.tempo_up = 1'b1;
    tick(25);
    bus.tempo_up = 1'b0;
    tick(15);
    check_state("hold_25_cycles");
    check_drained("hold");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_beat();
    test_stepping();
    test_both_buttons();
    test_mid_beat_change();
    test_reset_hold();
    test_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
